// File: rtl/pll_phase_ctrl_pkg.sv
// Shared types and encodings for the ECP5 EHXPLLL dynamic fine-phase sequencer.
package pll_phase_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_PULSE  = 3'd2,
      ST_GAP    = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

   localparam logic [1:0] SEL_CLKOS   = 2'b00;
   localparam logic [1:0] SEL_CLKOS2  = 2'b01;
   localparam logic [1:0] SEL_CLKOS3  = 2'b10;
   localparam logic [1:0] SEL_CLKOP   = 2'b11;

   localparam logic DIR_ADVANCE = 1'b1;
   localparam logic DIR_RETARD  = 1'b0;

   localparam int TMR_W = 16;

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// Request handshake between a phase requester (calibration FSM / debug regs) and the sequencer.
interface pll_phase_ctrl_if #(
   parameter int CNT_W = 6
) ();
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_sel;
   logic             req_dir;
   logic [CNT_W-1:0] req_count;

   modport master (
      output req_valid, req_sel, req_dir, req_count,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_sel, req_dir, req_count,
      output req_ready
   );
endinterface

// File: rtl/pll_phase_timer.sv
// Loadable down-counter shared by the SETUP, PULSE and GAP phases; expires after i_load cycles.
module pll_phase_timer
   import pll_phase_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_start,
   input  logic [W-1:0] i_load,
   output logic         o_expire
);

   logic [W-1:0] r_cnt;
   logic         r_run;

   // Count down from load-1 so the expire cycle is the last cycle of the interval
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {W{1'b0}};
         r_run <= 1'b0;
      end else if (i_start) begin
         r_cnt <= i_load - W'(1);
         r_run <= 1'b1;
      end else if (r_cnt != {W{1'b0}}) begin
         r_cnt <= r_cnt - W'(1);
         r_run <= r_run;
      end else begin
         r_cnt <= r_cnt;
         r_run <= 1'b0;
      end
   end

   assign o_expire = r_run && (r_cnt == {W{1'b0}});

endmodule

// File: rtl/pll_phase_ctrl.sv
// EHXPLLL fine-phase step sequencer with per-output position tracking.
// Position registers exist only when PLL_PHASE_TRACK_EN is defined; otherwise phase_pos reads 0.
module pll_phase_ctrl
   import pll_phase_pkg::*;
#(
   parameter int STEP_PULSE_CYCLES = 4,
   parameter int SETUP_CYCLES      = 2,
   parameter int SETTLE_CYCLES     = 16,
   parameter int N_STEPS           = 48,
   parameter int CNT_W             = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   pll_phase_ctrl_if.slave    req,
   input  logic               pll_locked,
   output logic [1:0]         phasesel,
   output logic               phasedir,
   output logic               phasestep,
   output logic               phaseloadreg,
   output logic               busy,
   output logic               done,
   output logic               lock_err,
   output logic [4*CNT_W-1:0] phase_pos
);

   state_e           r_state;
   state_e           w_next;
   logic             r_lock_meta;
   logic             r_lock_s;
   logic [1:0]       r_sel;
   logic             r_dir;
   logic [CNT_W-1:0] r_remain;
   logic             r_busy;
   logic             r_done;
   logic             r_lock_err;
   logic             w_accept;
   logic             w_abort;
   logic             w_step_done;
   logic             w_tmr_start;
   logic [TMR_W-1:0] w_tmr_load;
   logic             w_tmr_expire;

   assign w_accept    = req.req_valid && (r_state == ST_IDLE) && r_lock_s;
   assign w_abort     = !r_lock_s && ((r_state == ST_SETUP) || (r_state == ST_PULSE) ||
                                      (r_state == ST_GAP));
   assign w_step_done = (r_state == ST_GAP) && w_tmr_expire;

   // Two-flop synchroniser for the asynchronous PLL lock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
      end else begin
         r_lock_meta <= pll_locked;
         r_lock_s    <= r_lock_meta;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next-state logic; a step whose GAP ends as lock drops still counts
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_next = ST_SETUP;
            else          w_next = ST_IDLE;
         end
         ST_SETUP: begin
            if (!r_lock_s)                     w_next = ST_FINISH;
            else if (!w_tmr_expire)            w_next = ST_SETUP;
            else if (r_remain == {CNT_W{1'b0}}) w_next = ST_FINISH;
            else                               w_next = ST_PULSE;
         end
         ST_PULSE: begin
            if (!r_lock_s)         w_next = ST_FINISH;
            else if (w_tmr_expire) w_next = ST_GAP;
            else                   w_next = ST_PULSE;
         end
         ST_GAP: begin
            if (!r_lock_s)                  w_next = ST_FINISH;
            else if (!w_tmr_expire)         w_next = ST_GAP;
            else if (r_remain == CNT_W'(1)) w_next = ST_FINISH;
            else                            w_next = ST_PULSE;
         end
         ST_FINISH: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // FSM outputs: timer restart on entry to each timed phase, strobe and ready decode
   always_comb begin
      w_tmr_start = 1'b0;
      w_tmr_load  = TMR_W'(SETUP_CYCLES);
      if (w_next != r_state) begin
         case (w_next)
            ST_SETUP: begin
               w_tmr_start = 1'b1;
               w_tmr_load  = TMR_W'(SETUP_CYCLES);
            end
            ST_PULSE: begin
               w_tmr_start = 1'b1;
               w_tmr_load  = TMR_W'(STEP_PULSE_CYCLES);
            end
            ST_GAP: begin
               w_tmr_start = 1'b1;
               w_tmr_load  = TMR_W'(SETTLE_CYCLES);
            end
            default: begin
               w_tmr_start = 1'b0;
               w_tmr_load  = TMR_W'(SETUP_CYCLES);
            end
         endcase
      end else begin
         w_tmr_start = 1'b0;
      end
      if ((r_state == ST_PULSE) && r_lock_s) phasestep = 1'b0;
      else                                   phasestep = 1'b1;
      if ((r_state == ST_IDLE) && r_lock_s)  req.req_ready = 1'b1;
      else                                   req.req_ready = 1'b0;
   end

   pll_phase_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (w_tmr_start),
      .i_load   (w_tmr_load),
      .o_expire (w_tmr_expire)
   );

   // Request latch, remaining-step counter and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel      <= SEL_CLKOS;
         r_dir      <= DIR_RETARD;
         r_remain   <= {CNT_W{1'b0}};
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_lock_err <= 1'b0;
      end else begin
         r_busy <= (w_next == ST_SETUP) || (w_next == ST_PULSE) || (w_next == ST_GAP);
         r_done <= (w_next == ST_FINISH);
         if (w_accept) begin
            r_sel      <= req.req_sel;
            r_dir      <= req.req_dir;
            r_remain   <= req.req_count;
            r_lock_err <= 1'b0;
         end else begin
            if (w_step_done) r_remain <= r_remain - CNT_W'(1);
            if (w_abort)     r_lock_err <= 1'b1;
         end
      end
   end

   assign phasesel     = r_sel;
   assign phasedir     = r_dir;
   assign phaseloadreg = 1'b1;
   assign busy         = r_busy;
   assign done         = r_done;
   assign lock_err     = r_lock_err;

`ifdef PLL_PHASE_TRACK_EN
   logic [CNT_W-1:0] r_pos [4];

   function automatic logic [CNT_W-1:0] pos_next(input logic [CNT_W-1:0] p, input logic d);
      logic [CNT_W-1:0] n;
      if (d == DIR_ADVANCE) begin
         if (p == CNT_W'(N_STEPS - 1)) n = {CNT_W{1'b0}};
         else                          n = p + CNT_W'(1);
      end else begin
         if (p == {CNT_W{1'b0}}) n = CNT_W'(N_STEPS - 1);
         else                    n = p - CNT_W'(1);
      end
      return n;
   endfunction

   // Tracked position per output, moved once per completed step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) r_pos[i] <= {CNT_W{1'b0}};
      end else if (w_step_done) begin
         r_pos[r_sel] <= pos_next(r_pos[r_sel], r_dir);
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_pos
      assign phase_pos[g*CNT_W +: CNT_W] = r_pos[g];
   end
`else
   assign phase_pos = {(4*CNT_W){1'b0}};
`endif

endmodule
